pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage MIPS pipeline; drives the WEN/flush pair of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus PC write enable.
- Resolves data-memory wait, taken branch, load-use hazard, jump redirect, instruction-fetch miss and halt drain.
- Registered FSM plus counters; control outputs are combinational from state and current inputs.

---
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage MIPS pipeline: stage WEN/flush, PC enable, halt drain.
// Define PIPE_HAZARD_PERF_EN to add the stall/flush/cycle performance counters.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       mem_req,
  input  logic       mem_branch_taken,
  input  logic       id_jump,
  input  logic       id_halt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       pc_wen,
  output logic       ifid_wen,
  output logic       ifid_flush,
  output logic       idex_wen,
  output logic       idex_flush,
  output logic       exmem_wen,
  output logic       exmem_flush,
  output logic       memwb_wen,
  output logic       memwb_flush,
  output logic       halt,
  output logic [1:0] dbg_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [DW-1:0] drain_cnt, next_cnt;
  logic          freeze, load_use;
  logic          adv_if, adv_id, adv_ex, adv_wb;
  logic          fl_if, fl_id, fl_ex, fl_wb;

  // Once in DWAIT the freeze is held purely on dhit; mem_req is already latched by the stall.
  assign freeze    = (state == ST_DWAIT) ? !dhit : (mem_req && !dhit);
  assign load_use  = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = drain_cnt;
    unique case (state)
      ST_RUN, ST_DWAIT: begin
        // The dhit cycle of DWAIT decodes like RUN, so a held HALT is picked up here.
        if (freeze)                next_state = ST_DWAIT;
        else if (mem_branch_taken) next_state = ST_RUN;
        else if (load_use)         next_state = ST_RUN;
        else if (id_halt) begin
          next_state = ST_DRAIN;
          next_cnt   = DW'(DRAIN_CYCLES);
        end else                   next_state = ST_RUN;
      end
      ST_DRAIN: begin
        if (freeze) begin
          next_state = ST_DRAIN;
        end else if (mem_branch_taken) begin
          next_state = ST_RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) next_state = ST_HALTED;
        end
      end
      default: next_state = ST_HALTED;
    endcase
  end

  always_comb begin
    pc_wen = 1'b1;
    adv_if = 1'b1;
    adv_id = 1'b1;
    adv_ex = 1'b1;
    adv_wb = 1'b1;
    fl_if  = 1'b0;
    fl_id  = 1'b0;
    fl_ex  = 1'b0;
    fl_wb  = 1'b0;
    halt   = 1'b0;
    if (RST) begin
      pc_wen = 1'b0;
      {adv_if, adv_id, adv_ex, adv_wb} = 4'b0000;
      {fl_if, fl_id, fl_ex, fl_wb}     = 4'b1111;
    end else begin
      unique case (state)
        ST_RUN, ST_DWAIT: begin
          if (freeze) begin
            pc_wen = 1'b0;
            {adv_if, adv_id, adv_ex} = 3'b000;
            fl_wb = 1'b1;
          end else if (mem_branch_taken) begin
            {fl_if, fl_id, fl_ex} = 3'b111;
          end else if (load_use) begin
            pc_wen = 1'b0;
            adv_if = 1'b0;
            fl_id  = 1'b1;
          end else if (id_halt) begin
            pc_wen = 1'b0;
            fl_if  = 1'b1;
          end else if (id_jump) begin
            fl_if = 1'b1;
          end else if (!ihit) begin
            pc_wen = 1'b0;
            fl_if  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (freeze) begin
            pc_wen = 1'b0;
            {adv_if, adv_id, adv_ex} = 3'b000;
            {fl_if, fl_wb} = 2'b11;
          end else if (mem_branch_taken) begin
            {fl_if, fl_id, fl_ex} = 3'b111;
          end else begin
            pc_wen = 1'b0;
            fl_if  = 1'b1;
          end
        end
        default: begin
          pc_wen = 1'b0;
          {adv_if, adv_id, adv_ex, adv_wb} = 4'b0000;
          halt = 1'b1;
        end
      endcase
    end
    ifid_wen    = adv_if && !fl_if;
    ifid_flush  = fl_if;
    idex_wen    = adv_id && !fl_id;
    idex_flush  = fl_id;
    exmem_wen   = adv_ex && !fl_ex;
    exmem_flush = fl_ex;
    memwb_wen   = adv_wb && !fl_wb;
    memwb_flush = fl_wb;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic live, bj_flush;
  assign live     = (state != ST_HALTED);
  assign bj_flush = live && !freeze &&
                    (mem_branch_taken ||
                     ((state != ST_DRAIN) && !load_use && !id_halt && id_jump));

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (live && !pc_wen && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (bj_flush && (flush_cnt != '1))        flush_cnt <= flush_cnt + CNT_W'(1);
      if (live && (cycle_cnt != '1))            cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: rule-level model, per-cycle scoreboard, directed pins and random stimulus.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN_CYCLES = 3;
`ifdef PIPE_HAZARD_PERF_EN
  localparam int CNT_W = 32;
  localparam int W = 12 + 3 * CNT_W;
`else
  localparam int W = 12;
`endif
  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

  logic       CLK;
  logic       RST, ihit, dhit, mem_req, mem_branch_taken, id_jump, id_halt, idex_memread;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
  logic       exmem_wen, exmem_flush, memwb_wen, memwb_flush, halt;
  logic [1:0] dbg_state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, cycle_cnt;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_mode   = M_RUN;
  int m_left   = 0;
  int m_stalls = 0, m_flushes = 0, m_cycles = 0;

  pipe_hazard_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
`ifdef PIPE_HAZARD_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .mem_branch_taken(mem_branch_taken), .id_jump(id_jump), .id_halt(id_halt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .idex_wen(idex_wen), .idex_flush(idex_flush), .exmem_wen(exmem_wen),
    .exmem_flush(exmem_flush), .memwb_wen(memwb_wen), .memwb_flush(memwb_flush),
    .halt(halt), .dbg_state(dbg_state)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  // Clock and global time bound
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [W-1:0] dut_vec();
    logic [W-1:0] v;
    v = '0;
    v[11:0] = {dbg_state, halt, pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
               exmem_wen, exmem_flush, memwb_wen, memwb_flush};
`ifdef PIPE_HAZARD_PERF_EN
    v[W-1:12] = {stall_cnt, flush_cnt, cycle_cnt};
`endif
    return v;
  endfunction

  // Scoreboard: one expectation per driven cycle, compared mid-cycle
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = dut_vec();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: expected outputs from the event rules, then advance the model
  task automatic step(input bit chk);
    bit pc, a_if, a_id, a_ex, a_wb, f_if, f_id, f_ex, f_wb, h, lu, bj, stalled;
    int st, nm;
    logic [W-1:0] e;
    st = m_mode; nm = m_mode;
    pc = 1; a_if = 1; a_id = 1; a_ex = 1; a_wb = 1;
    f_if = 0; f_id = 0; f_ex = 0; f_wb = 0; h = 0; bj = 0;
    lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (RST) begin
      pc = 0; a_if = 0; a_id = 0; a_ex = 0; a_wb = 0; f_if = 1; f_id = 1; f_ex = 1; f_wb = 1;
    end else if (m_mode == M_HALT) begin
      pc = 0; a_if = 0; a_id = 0; a_ex = 0; a_wb = 0; h = 1;
    end else if (m_mode == M_DRAIN) begin
      if (mem_req && !dhit) begin
        pc = 0; a_if = 0; a_id = 0; a_ex = 0; f_if = 1; f_wb = 1;
      end else if (mem_branch_taken) begin
        f_if = 1; f_id = 1; f_ex = 1; bj = 1; nm = M_RUN; m_left = 0;
      end else begin
        pc = 0; f_if = 1;
        m_left = m_left - 1;
        if (m_left == 0) nm = M_HALT;
      end
    end else begin
      stalled = (m_mode == M_WAIT) ? !dhit : (mem_req && !dhit);
      if (stalled) begin
        pc = 0; a_if = 0; a_id = 0; a_ex = 0; f_wb = 1; nm = M_WAIT;
      end else begin
        nm = M_RUN;
        if (mem_branch_taken) begin f_if = 1; f_id = 1; f_ex = 1; bj = 1; end
        else if (lu) begin pc = 0; a_if = 0; f_id = 1; end
        else if (id_halt) begin pc = 0; f_if = 1; nm = M_DRAIN; m_left = DRAIN_CYCLES; end
        else if (id_jump) begin f_if = 1; bj = 1; end
        else if (!ihit) begin pc = 0; f_if = 1; end
      end
    end
    e = '0;
    e[11:0] = {2'(st), h, pc, a_if & !f_if, f_if, a_id & !f_id, f_id,
               a_ex & !f_ex, f_ex, a_wb & !f_wb, f_wb};
`ifdef PIPE_HAZARD_PERF_EN
    e[W-1:12] = {CNT_W'(m_stalls), CNT_W'(m_flushes), CNT_W'(m_cycles)};
`endif
    if (chk) exp_q.push_back(e);
    if (RST) begin
      m_mode = M_RUN; m_left = 0; m_stalls = 0; m_flushes = 0; m_cycles = 0;
    end else begin
      if (st != M_HALT) begin
        m_cycles++;
        if (!pc) m_stalls++;
        if (bj) m_flushes++;
      end
      m_mode = nm;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; mem_req = 0; mem_branch_taken = 0; id_jump = 0;
    id_halt = 0; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin step(1); tick(); end
  endtask

  initial begin
    idle(); RST = 1; step(0); tick();
    RST = 1; step(1); #2;
    lit("rst_flush", {ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, pc_wen}, 6'b111100);
    tick();
    idle(); step(1); #2;
    lit("idle_out", {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush}, 9'b111110000);
    tick();

    idex_memread = 1; idex_rt = 5; ifid_rs = 5; step(1); #2;
    lit("load_use", {pc_wen, ifid_wen, idex_flush, exmem_wen}, 4'b0011);
    tick();
    idex_rt = 0; ifid_rs = 0; step(1); #2;
    lit("load_use_r0", {pc_wen, ifid_wen, idex_flush}, 3'b110);
    tick();

    idle(); mem_req = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin idex_memread = 1; idex_rt = 7; ifid_rt = 7; end
      step(1); #2;
      if (i == 2) lit("dwait_hold", {dbg_state, memwb_flush, pc_wen, exmem_wen}, 5'b01100);
      tick();
    end
    idle(); mem_req = 1; dhit = 1; step(1); #2;
    lit("dwait_release", {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen}, 5'b11111);
    tick();

    idle(); mem_branch_taken = 1; id_jump = 1; idex_memread = 1; idex_rt = 3; ifid_rs = 3;
    step(1); #2;
    lit("branch_prio", {ifid_flush, idex_flush, exmem_flush, pc_wen, memwb_wen}, 5'b11111);
    tick();

    idle(); id_halt = 1; run(1);
    idle(); run(1);
    mem_req = 1; dhit = 0; run(1);
    idle(); run(2);
    step(1); #2; lit("halt_set", {halt, pc_wen}, 2'b10); tick();
    run(3);
    RST = 1; run(1);
    idle(); id_halt = 1; run(1);
    idle(); run(1);
    mem_branch_taken = 1; run(1);
    idle(); step(1); #2; lit("drain_branch_exit", {halt, dbg_state}, 3'b000); tick();
    run(4);

`ifdef PIPE_HAZARD_PERF_EN
    RST = 1; run(1);
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 2 || i == 5) begin idex_memread = 1; idex_rt = 4; ifid_rt = 4; end
      if (i == 7) id_jump = 1;
      run(1);
    end
    idle(); step(1); #2;
    lit("perf_stall", stall_cnt, 32'd2);
    lit("perf_flush", flush_cnt, 32'd1);
    lit("perf_cycle", cycle_cnt, 32'd10);
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      RST              = ($urandom_range(0, 59) == 0) ||
                         (m_mode == M_HALT && $urandom_range(0, 5) == 0);
      ihit             = ($urandom_range(0, 3) != 0);
      dhit             = ($urandom_range(0, 2) != 0);
      mem_req          = ($urandom_range(0, 3) == 0);
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      id_jump          = ($urandom_range(0, 7) == 0);
      id_halt          = ($urandom_range(0, 11) == 0);
      idex_memread     = ($urandom_range(0, 2) == 0);
      idex_rt          = 5'($urandom_range(0, 3));
      ifid_rs          = 5'($urandom_range(0, 3));
      ifid_rt          = 5'($urandom_range(0, 3));
      run(1);
    end
    idle(); run(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
